// File: rtl/seg7_reader.sv
// seg7_reader
//
// Receive side of a multiplexed, active-low 7-segment display bus. The raw
// segment lines and digit selects are brought into the clock domain through a
// two-flop synchronizer. A small settle filter then waits until the synced
// (select, segment) pair has been identical for STABLE_CYC consecutive cycles
// before accepting it, so multiplex ghosting during digit changes is rejected.
// Each accepted pattern is decoded back to BCD. Once every digit has been
// accepted at least once, the whole frame is published with a one-cycle pulse.
//
// Ports
//   clk          in   1        rising-edge clock
//   rst_n        in   1        asynchronous active-low reset
//   seg_n        in   7        segment lines, active-low, bit0=a .. bit6=g
//   digit_sel_n  in   NDIG     digit enables, active-low, one-hot-low when valid
//   digits       out  4*NDIG   BCD per digit, digit k at [4k+3:4k], 4'hF = blank
//   digit_err    out  NDIG     last accepted pattern for digit k was illegal
//   frame_valid  out  1        one-cycle pulse when a complete new frame is held
//   stale        out  1        no frame completed within STALE_CYC cycles
module seg7_reader #(
    parameter int NDIG       = 4,
    parameter int STABLE_CYC = 4,
    parameter int STALE_CYC  = 4096
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [6:0]          seg_n,
    input  logic [NDIG-1:0]     digit_sel_n,
    output logic [4*NDIG-1:0]   digits,
    output logic [NDIG-1:0]     digit_err,
    output logic                frame_valid,
    output logic                stale
);

    localparam int CNT_W = $clog2(STABLE_CYC + 1);
    localparam int STL_W = $clog2(STALE_CYC + 1);
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int ZC_W  = $clog2(NDIG + 1);

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYC);
    localparam logic [STL_W-1:0] STALE_MAX   = STL_W'(STALE_CYC);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HELD   = 2'd2
    } readerState_e;

    logic [6:0]        segMeta_q, segSync_q;
    logic [NDIG-1:0]   selMeta_q, selSync_q;

    readerState_e      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [6:0]        refSeg_q, refSeg_d;
    logic [NDIG-1:0]   refSel_q, refSel_d;
    logic [4*NDIG-1:0] digits_q, digits_d;
    logic [NDIG-1:0]   err_q, err_d;
    logic [NDIG-1:0]   seen_q, seen_d;
    logic              frame_q, frame_d;
    logic [STL_W-1:0]  staleCnt_q, staleCnt_d;

    logic [ZC_W-1:0]   zeroCount;
    logic [IDX_W-1:0]  selIdx;
    logic              selValid;
    logic              patChanged;
    logic              accept;
    logic [4:0]        decoded;

    // Maps an active-low pattern (g..a, MSB first) to {err, bcd}.
    // All segments dark is a legitimate blank digit, not an error.
    function automatic logic [4:0] decodeSeg(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'b1000000: r = 5'h00;
            7'b1111001: r = 5'h01;
            7'b0100100: r = 5'h02;
            7'b0110000: r = 5'h03;
            7'b0011001: r = 5'h04;
            7'b0010010: r = 5'h05;
            7'b0000010: r = 5'h06;
            7'b1111000: r = 5'h07;
            7'b0000000: r = 5'h08;
            7'b0010000: r = 5'h09;
            7'b1111111: r = 5'h0F;
            default:    r = 5'h1F;
        endcase
        return r;
    endfunction

    // Two-flop synchronizer; resets to all-ones so nothing looks selected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            segMeta_q <= '1;
            segSync_q <= '1;
            selMeta_q <= '1;
            selSync_q <= '1;
        end else begin
            segMeta_q <= seg_n;
            segSync_q <= segMeta_q;
            selMeta_q <= digit_sel_n;
            selSync_q <= selMeta_q;
        end
    end

    // The select is usable only when exactly one line is low; selIdx is
    // only meaningful in that case.
    always_comb begin
        zeroCount = '0;
        selIdx    = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (!selSync_q[i]) begin
                zeroCount = zeroCount + ZC_W'(1);
                selIdx    = IDX_W'(i);
            end
        end
    end

    assign selValid   = (zeroCount == ZC_W'(1));
    assign patChanged = (segSync_q != refSeg_q) || (selSync_q != refSel_q);
    assign decoded    = decodeSeg(segSync_q);

    // Settle filter, digit capture, frame assembly and stale timer.
    // Switching to another digit changes the synced pair, so it restarts the
    // filter exactly like a ghosting segment change does.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        refSeg_d   = refSeg_q;
        refSel_d   = refSel_q;
        digits_d   = digits_q;
        err_d      = err_q;
        seen_d     = seen_q;
        frame_d    = 1'b0;
        accept     = 1'b0;

        case (state_q)
            IDLE: begin
                if (selValid) begin
                    state_d  = SETTLE;
                    cnt_d    = CNT_ONE;
                    refSeg_d = segSync_q;
                    refSel_d = selSync_q;
                end
            end
            SETTLE: begin
                if (!selValid) begin
                    state_d = IDLE;
                end else if (patChanged) begin
                    cnt_d    = CNT_ONE;
                    refSeg_d = segSync_q;
                    refSel_d = selSync_q;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_d == STABLE_LAST) begin
                        accept  = 1'b1;
                        state_d = HELD;
                    end
                end
            end
            HELD: begin
                if (!selValid) begin
                    state_d = IDLE;
                end else if (patChanged) begin
                    state_d  = SETTLE;
                    cnt_d    = CNT_ONE;
                    refSeg_d = segSync_q;
                    refSel_d = selSync_q;
                end
            end
            default: state_d = IDLE;
        endcase

        for (int k = 0; k < NDIG; k++) begin
            if (accept && (selIdx == IDX_W'(k))) begin
                digits_d[4*k +: 4] = decoded[3:0];
                err_d[k]           = decoded[4];
                seen_d[k]          = 1'b1;
            end
        end

        // The digit captured on this edge counts toward the frame it completes.
        if (accept && (&seen_d)) begin
            frame_d = 1'b1;
            seen_d  = '0;
        end

        if (frame_d) begin
            staleCnt_d = '0;
        end else if (staleCnt_q == STALE_MAX) begin
            staleCnt_d = staleCnt_q;
        end else begin
            staleCnt_d = staleCnt_q + STL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            refSeg_q   <= '1;
            refSel_q   <= '1;
            digits_q   <= '1;
            err_q      <= '0;
            seen_q     <= '0;
            frame_q    <= 1'b0;
            staleCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            refSeg_q   <= refSeg_d;
            refSel_q   <= refSel_d;
            digits_q   <= digits_d;
            err_q      <= err_d;
            seen_q     <= seen_d;
            frame_q    <= frame_d;
            staleCnt_q <= staleCnt_d;
        end
    end

    assign digits      = digits_q;
    assign digit_err   = err_q;
    assign frame_valid = frame_q;
    assign stale       = (staleCnt_q == STALE_MAX);

endmodule

// File: tb/tb_seg7_reader.sv
// tb_seg7_reader
//
// Directed bench for seg7_reader (NDIG=4, STABLE_CYC=4, STALE_CYC=4096).
// A reference model describes acceptance as "a valid synced pair has been
// seen for exactly STABLE_CYC consecutive cycles" and tracks the frame and
// stale rules directly; every cycle the DUT outputs are compared to it.
// Hand-computed literal expectations after each scenario pin the model.
module tb_seg7_reader;

    localparam int NDIG       = 4;
    localparam int STABLE_CYC = 4;
    localparam int STALE_CYC  = 4096;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [6:0]  seg_n = 7'h7F;
    logic [3:0]  digit_sel_n = 4'hF;
    logic [15:0] digits;
    logic [3:0]  digit_err;
    logic        frame_valid;
    logic        stale;

    int vecCount = 0;
    int missCount = 0;

    seg7_reader #(
        .NDIG(NDIG),
        .STABLE_CYC(STABLE_CYC),
        .STALE_CYC(STALE_CYC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .seg_n(seg_n),
        .digit_sel_n(digit_sel_n),
        .digits(digits),
        .digit_err(digit_err),
        .frame_valid(frame_valid),
        .stale(stale)
    );

    always #5 clk = ~clk;

    // Active-low segment codes for 0..9, g..a MSB first.
    logic [6:0] segTable [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    // Reference model state.
    logic [6:0]  mS1Seg = '1, mS2Seg = '1, prevSeg = '1;
    logic [3:0]  mS1Sel = '1, mS2Sel = '1, prevSel = '1;
    bit          havePrev = 0;
    int          runLen = 0;
    logic [15:0] expDigits = 16'hFFFF;
    logic [3:0]  expErr = '0;
    logic [3:0]  seenM = '0;
    bit          expFrame = 0;
    int          sinceFrame = 0;

    // Observations of the DUT frame pulses.
    int   framesSeen = 0;
    logic prevStale = 1'b0;
    logic staleBeforeFrame = 1'b0;
    logic staleAtFrame = 1'b1;

    function automatic void decodeModel(input logic [6:0] s, output logic [3:0] v, output logic e);
        v = 4'hF;
        e = (s != 7'h7F);
        for (int d = 0; d < 10; d++) begin
            if (s == segTable[d]) begin
                v = 4'(d);
                e = 1'b0;
            end
        end
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s at %0t: got 'h%0h, required 'h%0h", name, $time, act, exp);
        end
    endtask

    // Model: the pair seen by the filter is the raw input two edges ago.
    always @(posedge clk or negedge rst_n) begin : mdl
        logic [6:0]  pSeg;
        logic [3:0]  pSel;
        int          zeros, idx, runNext, sinceNext;
        logic [3:0]  nib;
        logic        bad;
        logic [15:0] digNext;
        logic [3:0]  errNext, seenNext;
        bit          frameNext;
        if (!rst_n) begin
            mS1Seg     <= '1;
            mS2Seg     <= '1;
            mS1Sel     <= '1;
            mS2Sel     <= '1;
            prevSeg    <= '1;
            prevSel    <= '1;
            havePrev   <= 0;
            runLen     <= 0;
            expDigits  <= 16'hFFFF;
            expErr     <= '0;
            seenM      <= '0;
            expFrame   <= 0;
            sinceFrame <= 0;
        end else begin
            pSeg  = mS2Seg;
            pSel  = mS2Sel;
            zeros = 0;
            idx   = 0;
            for (int i = 0; i < NDIG; i++) begin
                if (!pSel[i]) begin
                    zeros++;
                    idx = i;
                end
            end
            if (zeros != 1)
                runNext = 0;
            else if (havePrev && pSeg == prevSeg && pSel == prevSel)
                runNext = runLen + 1;
            else
                runNext = 1;
            digNext   = expDigits;
            errNext   = expErr;
            seenNext  = seenM;
            frameNext = 0;
            sinceNext = (sinceFrame < STALE_CYC) ? sinceFrame + 1 : sinceFrame;
            if (runNext == STABLE_CYC) begin
                decodeModel(pSeg, nib, bad);
                digNext[4*idx +: 4] = nib;
                errNext[idx]        = bad;
                seenNext[idx]       = 1'b1;
                if (seenNext == 4'hF) begin
                    frameNext = 1;
                    seenNext  = '0;
                    sinceNext = 0;
                end
            end
            mS2Seg     <= mS1Seg;
            mS2Sel     <= mS1Sel;
            mS1Seg     <= seg_n;
            mS1Sel     <= digit_sel_n;
            prevSeg    <= pSeg;
            prevSel    <= pSel;
            havePrev   <= (zeros == 1);
            runLen     <= runNext;
            expDigits  <= digNext;
            expErr     <= errNext;
            seenM      <= seenNext;
            expFrame   <= frameNext;
            sinceFrame <= sinceNext;
        end
    end

    // Every-cycle compare against the model, away from the rising edge.
    always @(negedge clk) begin
        checkOutput("digits", 32'(digits), 32'(expDigits));
        checkOutput("digit_err", 32'(digit_err), 32'(expErr));
        checkOutput("frame_valid", 32'(frame_valid), 32'(expFrame));
        checkOutput("stale", 32'(stale), 32'(sinceFrame >= STALE_CYC));
        if (frame_valid) begin
            framesSeen++;
            staleAtFrame     = stale;
            staleBeforeFrame = prevStale;
        end
        prevStale = stale;
    end

    // Drives one input pattern from a falling edge and holds it for some cycles.
    task automatic applyStimulus(input logic [3:0] sel, input logic [6:0] seg, input int cycles);
        digit_sel_n = sel;
        seg_n       = seg;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic scanDigit(input int k, input int d);
        logic [3:0] sel;
        sel = ~(4'b0001 << k);
        applyStimulus(sel, segTable[d], 10);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_digits"}, 32'(digits), 32'hFFFF);
        checkOutput({tag, "_err"}, 32'(digit_err), 32'h0);
        checkOutput({tag, "_frame"}, 32'(frame_valid), 32'h0);
        checkOutput({tag, "_stale"}, 32'(stale), 32'h0);
    endtask

    initial begin
        int f0;
        #1 rst_n = 1'b0;
        #1 checkReset("por");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Plain scan of 1,2,3,4.
        f0 = framesSeen;
        scanDigit(0, 1); scanDigit(1, 2); scanDigit(2, 3); scanDigit(3, 4);
        applyStimulus(4'hF, 7'h7F, 4);
        checkOutput("t1_frames", 32'(framesSeen - f0), 32'd1);
        checkOutput("t1_digits", 32'(digits), 32'h4321);
        checkOutput("t1_err", 32'(digit_err), 32'h0);

        // Three stable samples are not enough; four are, six cycles after the change.
        applyStimulus(4'b1110, segTable[6], 3);
        applyStimulus(4'b1110, segTable[7], 3);
        digit_sel_n = 4'b1110;
        seg_n       = segTable[6];
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            checkOutput($sformatf("t2_latency_c%0d", c), 32'(digits[3:0]), (c < 6) ? 32'h1 : 32'h6);
        end
        checkOutput("t2_digits", 32'(digits), 32'h4326);

        // Illegal pattern on digit 2, then replaced by a legal 7.
        f0 = framesSeen;
        scanDigit(1, 2);
        applyStimulus(4'b1011, 7'b0000001, 10);
        scanDigit(3, 4);
        applyStimulus(4'hF, 7'h7F, 4);
        checkOutput("t3_frames", 32'(framesSeen - f0), 32'd1);
        checkOutput("t3_digits", 32'(digits), 32'h4F26);
        checkOutput("t3_err", 32'(digit_err), 32'h4);
        scanDigit(0, 6); scanDigit(1, 2); scanDigit(2, 7); scanDigit(3, 4);
        applyStimulus(4'hF, 7'h7F, 4);
        checkOutput("t3b_frames", 32'(framesSeen - f0), 32'd2);
        checkOutput("t3b_digits", 32'(digits), 32'h4726);
        checkOutput("t3b_err", 32'(digit_err), 32'h0);

        // Multiple / no selects keep the seen mask.
        f0 = framesSeen;
        scanDigit(0, 9); scanDigit(1, 5);
        applyStimulus(4'b1100, segTable[8], 20);
        applyStimulus(4'b1111, segTable[8], 20);
        checkOutput("t4_noframe", 32'(framesSeen - f0), 32'd0);
        checkOutput("t4_digits", 32'(digits), 32'h4759);
        scanDigit(2, 3); scanDigit(3, 8);
        applyStimulus(4'hF, 7'h7F, 4);
        checkOutput("t4_frames", 32'(framesSeen - f0), 32'd1);
        checkOutput("t4_digits2", 32'(digits), 32'h8359);

        // Stale detection and clearing.
        applyStimulus(4'hF, 7'h7F, STALE_CYC + 10);
        checkOutput("t5_stale", 32'(stale), 32'h1);
        f0 = framesSeen;
        scanDigit(0, 0); scanDigit(1, 1); scanDigit(2, 2); scanDigit(3, 3);
        applyStimulus(4'hF, 7'h7F, 4);
        checkOutput("t5_frames", 32'(framesSeen - f0), 32'd1);
        checkOutput("t5_stale_before", 32'(staleBeforeFrame), 32'h1);
        checkOutput("t5_stale_at_frame", 32'(staleAtFrame), 32'h0);
        checkOutput("t5_digits", 32'(digits), 32'h3210);

        // Reset while the third digit is settling.
        f0 = framesSeen;
        scanDigit(0, 5); scanDigit(1, 6);
        applyStimulus(4'b1011, segTable[7], 3);
        #2 rst_n = 1'b0;
        #1 checkReset("t6");
        @(negedge clk);
        applyStimulus(4'hF, 7'h7F, 1);
        rst_n = 1'b1;
        applyStimulus(4'hF, 7'h7F, 2);
        scanDigit(2, 7); scanDigit(3, 1);
        applyStimulus(4'hF, 7'h7F, 4);
        checkOutput("t6_noframe", 32'(framesSeen - f0), 32'd0);
        checkOutput("t6_digits", 32'(digits), 32'h17FF);
        scanDigit(0, 5); scanDigit(1, 6);
        applyStimulus(4'hF, 7'h7F, 4);
        checkOutput("t6_frames", 32'(framesSeen - f0), 32'd1);
        checkOutput("t6_digits2", 32'(digits), 32'h1765);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
